rand_show_ctrl: RTL and testbench

Capture-and-display controller downstream of the 8-bit LFSR random generator on the board top. It debounces a pushbutton, issues a one-cycle `step` advance pulse to the LFSR per press (or periodically in auto mode), and latches the resulting value. It drives two active-low hexadecimal seven-segment digits with the latched value.

---
 rtl/rand_show_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_rand_show_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_show_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rand_show_ctrl
// Brief    : Capture-and-display controller for the board LFSR. Debounces a
//            pushbutton (or self-triggers periodically in auto mode), issues a
//            one-cycle advance pulse to the LFSR, latches the advanced value
//            and drives two active-low hex seven-segment digits with it.
// Ports    : clk      - clock
//            rst_n    - asynchronous active-low reset
//            key_n    - raw bouncy pushbutton, active-low, asynchronous
//            auto_en  - auto-trigger enable switch, asynchronous
//            data_in  - current LFSR value
//            step     - one-cycle LFSR advance request
//            shown    - last captured LFSR value
//            valid    - at least one capture has completed
//            seg_hi   - active-low segments (gfedcba) for shown[7:4]
//            seg_lo   - active-low segments (gfedcba) for shown[3:0]
// Revision : 1.0 - initial release
// ============================================================================
module rand_show_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    input  logic       auto_en,
    input  logic [7:0] data_in,
    output logic       step,
    output logic [7:0] shown,
    output logic       valid,
    output logic [6:0] seg_hi,
    output logic [6:0] seg_lo
);

    localparam int c_DB_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_AUTO_CNT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

    localparam logic [c_DB_CNT_W-1:0]   c_DB_LAST   = c_DB_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_AUTO_CNT_W-1:0] c_AUTO_LAST = c_AUTO_CNT_W'(AUTO_PERIOD - 1);

    localparam logic [6:0] c_SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_CAP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizers. The key chain resets to the released level
    // so that reset never looks like a press.
    // ------------------------------------------------------------------
    logic r_key_s1;
    logic r_key_s2;
    logic r_auto_s1;
    logic r_auto_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_s1  <= 1'b1;
            r_key_s2  <= 1'b1;
            r_auto_s1 <= 1'b0;
            r_auto_s2 <= 1'b0;
        end else begin
            r_key_s1  <= key_n;
            r_key_s2  <= r_key_s1;
            r_auto_s1 <= auto_en;
            r_auto_s2 <= r_auto_s1;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer: the accepted level only follows the synchronized key
    // after DEBOUNCE_CYCLES consecutive differing samples; any sample
    // agreeing with the accepted level restarts the count.
    // ------------------------------------------------------------------
    logic                  r_db;
    logic                  r_db_q;
    logic [c_DB_CNT_W-1:0] r_db_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db     <= 1'b1;
            r_db_cnt <= '0;
        end else if (r_key_s2 == r_db) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
            r_db     <= ~r_db;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_q <= 1'b1;
        end else begin
            r_db_q <= r_db;
        end
    end

    // Press is the cycle in which the accepted level has just become 0
    // while the previous cycle's level was still 1.
    logic w_press;
    assign w_press = r_db_q & ~r_db;

    // ------------------------------------------------------------------
    // Auto timer: free-running modulo counter while enabled, parked at 0
    // otherwise. The tick marks the wrap cycle.
    // ------------------------------------------------------------------
    logic [c_AUTO_CNT_W-1:0] r_auto_cnt;
    logic                    w_tick;

    assign w_tick = r_auto_s2 && (r_auto_cnt == c_AUTO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_cnt <= '0;
        end else if (!r_auto_s2) begin
            r_auto_cnt <= '0;
        end else if (r_auto_cnt == c_AUTO_LAST) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + 1'b1;
        end
    end

    logic w_trigger;
    assign w_trigger = w_press | w_tick;

    // ------------------------------------------------------------------
    // Sequencer: IDLE -> STEP (advance LFSR) -> CAP (latch) -> IDLE.
    // Triggers are only looked at in IDLE, so anything arriving while a
    // capture is in flight is dropped.
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;
    logic   w_step;
    logic   w_capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_step       = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_state_next = S_STEP;
                end
            end
            S_STEP: begin
                w_step       = 1'b1;
                w_state_next = S_CAP;
            end
            S_CAP: begin
                w_capture    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The LFSR shifted on the edge that closed STEP, so data_in during CAP
    // already holds the advanced value.
    logic [7:0] r_shown;
    logic       r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shown <= 8'h00;
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_shown <= data_in;
            r_valid <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Hex decode, active-low, bit0 = a ... bit6 = g.
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_hex7(input logic [3:0] nib);
        logic [6:0] seg;
        seg = c_SEG_BLANK;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = c_SEG_BLANK;
        endcase
        return seg;
    endfunction

    assign step   = w_step;
    assign shown  = r_shown;
    assign valid  = r_valid;
    assign seg_hi = r_valid ? f_hex7(r_shown[7:4]) : c_SEG_BLANK;
    assign seg_lo = r_valid ? f_hex7(r_shown[3:0]) : c_SEG_BLANK;

endmodule
`default_nettype wire

// File: tb/tb_rand_show_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rand_show_ctrl
// Brief    : Self-checking bench for rand_show_ctrl. Models the board LFSR
//            (advances on every sampled step) and checks step timing, step
//            counts, captured values and segment patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rand_show_ctrl;

    localparam int DEB = 4;
    localparam int PER = 8;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [7:0] AUTO_SEQ [5] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'h78};

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       key_n   = 1'b1;
    logic       auto_en = 1'b0;
    logic [7:0] data_in;
    logic       step;
    logic [7:0] shown;
    logic       valid;
    logic [6:0] seg_hi;
    logic [6:0] seg_lo;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    int n_steps = 0;

    rand_show_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .AUTO_PERIOD    (PER)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_n  (key_n),
        .auto_en(auto_en),
        .data_in(data_in),
        .step   (step),
        .shown  (shown),
        .valid  (valid),
        .seg_hi (seg_hi),
        .seg_lo (seg_lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Board LFSR: right shift, feedback into the MSB; advances once per step.
    logic [7:0] lfsr = 8'h01;
    logic       seed_req = 1'b0;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[0] ^ v[4] ^ v[7], v[7:1]};
    endfunction

    always @(posedge clk) begin
        if (seed_req)
            lfsr <= 8'h01;
        else if (step === 1'b1)
            lfsr <= lfsr_next(lfsr);
    end
    assign data_in = lfsr;

    always @(negedge clk) begin
        if (step === 1'b1) n_steps <= n_steps + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------
    task automatic do_reset();
        rst_n    = 1'b0;
        key_n    = 1'b1;
        auto_en  = 1'b0;
        seed_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        seed_req = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance to just after the posedge that makes cyc == target.
    task automatic goto_cyc(input int target);
        if (target > cyc) repeat (target - cyc) @(posedge clk);
        #1;
    endtask

    // Returns cyc of the first cycle with step high, or -1 on timeout.
    task automatic wait_step(input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        int highs;
        highs = 0;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (step !== 1'b0) highs++;
        end
        checks++; if (highs !== 0) $display("FAIL reset_no_step: got %0d step cycles, expected 0", highs); else passed++;
        checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", valid); else passed++;
        checks++; if (shown !== 8'h00) $display("FAIL reset_shown: got %h, expected 00", shown); else passed++;
        checks++; if (seg_hi !== 7'h7F) $display("FAIL reset_seg_hi: got %h, expected 7f", seg_hi); else passed++;
        checks++; if (seg_lo !== 7'h7F) $display("FAIL reset_seg_lo: got %h, expected 7f", seg_lo); else passed++;
    endtask

    // key_n driven just after posedge t: first sampled at t+1, synchronized
    // at t+2, DEB differing cycles toggle db at edge t+DEB+2, press in that
    // cycle, step in the cycle starting at edge t+DEB+3.
    task automatic test_clean_press();
        int t;
        int ts;
        int n0;
        do_reset();
        cycles(2);
        n0 = n_steps;
        t = cyc;
        key_n = 1'b0;
        wait_step(DEB + 20, ts);
        checks++; if (ts !== t + DEB + 3) $display("FAIL press_latency: got cycle %0d, expected %0d", ts, t + DEB + 3); else passed++;
        goto_cyc(t + 20);
        key_n = 1'b1;
        cycles(DEB + 20);
        checks++; if (n_steps - n0 !== 1) $display("FAIL press_step_count: got %0d, expected 1", n_steps - n0); else passed++;
        checks++; if (shown !== 8'h80) $display("FAIL press_shown: got %h, expected 80", shown); else passed++;
        checks++; if (valid !== 1'b1) $display("FAIL press_valid: got %b, expected 1", valid); else passed++;
        checks++; if (seg_hi !== 7'h00) $display("FAIL press_seg_hi: got %h, expected 00", seg_hi); else passed++;
        checks++; if (seg_lo !== 7'h40) $display("FAIL press_seg_lo: got %h, expected 40", seg_lo); else passed++;
    endtask

    task automatic test_bounce();
        int t;
        int ts;
        int n0;
        logic [7:0] exp_v;
        n0 = n_steps;
        exp_v = lfsr_next(lfsr);
        for (int i = 0; i < 10; i++) begin
            key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            cycles(2);
        end
        t = cyc;
        key_n = 1'b0;
        wait_step(DEB + 20, ts);
        checks++; if (ts !== t + DEB + 3) $display("FAIL bounce_latency: got cycle %0d, expected %0d", ts, t + DEB + 3); else passed++;
        goto_cyc(t + 20);
        for (int i = 0; i < 10; i++) begin
            key_n = (i % 2 == 0) ? 1'b1 : 1'b0;
            cycles(2);
        end
        key_n = 1'b1;
        cycles(DEB + 20);
        checks++; if (n_steps - n0 !== 1) $display("FAIL bounce_step_count: got %0d, expected 1", n_steps - n0); else passed++;
        checks++; if (shown !== exp_v) $display("FAIL bounce_shown: got %h, expected %h", shown, exp_v); else passed++;
        checks++; if (seg_lo !== SEG_TBL[exp_v[3:0]]) $display("FAIL bounce_seg_lo: got %h, expected %h", seg_lo, SEG_TBL[exp_v[3:0]]); else passed++;
    endtask

    task automatic test_random_presses();
        int n0;
        logic [7:0] exp_v;
        for (int p = 0; p < 6; p++) begin
            n0 = n_steps;
            exp_v = lfsr_next(lfsr);
            for (int b = 0; b < int'($urandom_range(4, 0)); b++) begin
                key_n = 1'b0; cycles(int'($urandom_range(DEB - 1, 1)));
                key_n = 1'b1; cycles(int'($urandom_range(3, 1)));
            end
            key_n = 1'b0;
            cycles(int'($urandom_range(DEB + 10, DEB + 2)));
            for (int b = 0; b < int'($urandom_range(4, 0)); b++) begin
                key_n = 1'b1; cycles(int'($urandom_range(DEB - 1, 1)));
                key_n = 1'b0; cycles(int'($urandom_range(3, 1)));
            end
            key_n = 1'b1;
            cycles(DEB + 8 + int'($urandom_range(6, 0)));
            checks++; if (n_steps - n0 !== 1) $display("FAIL rand_press%0d_count: got %0d, expected 1", p, n_steps - n0); else passed++;
            checks++; if (shown !== exp_v) $display("FAIL rand_press%0d_shown: got %h, expected %h", p, shown, exp_v); else passed++;
            checks++; if (seg_hi !== SEG_TBL[exp_v[7:4]]) $display("FAIL rand_press%0d_seg_hi: got %h, expected %h", p, seg_hi, SEG_TBL[exp_v[7:4]]); else passed++;
        end
    endtask

    // auto_en raised just after edge t0: synchronized at t0+2, counter
    // reaches PER-1 in the cycle from edge t0+PER+1, step follows at
    // t0+PER+2 and then every PER cycles. Dropping auto_en after edge
    // t0+40 leaves it synchronized-high through the tick at t0+41.
    task automatic test_auto();
        int t0;
        int ts;
        int n0;
        do_reset();
        cycles(2);
        n0 = n_steps;
        t0 = cyc;
        auto_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_step(PER + 20, ts);
            checks++; if (ts !== t0 + PER + 2 + k * PER) $display("FAIL auto_step%0d_time: got cycle %0d, expected %0d", k, ts, t0 + PER + 2 + k * PER); else passed++;
            if (k == 4) begin
                @(negedge clk);
                @(negedge clk);
            end else begin
                @(negedge clk);
                @(negedge clk);
            end
            checks++; if (shown !== AUTO_SEQ[k]) $display("FAIL auto_shown%0d: got %h, expected %h", k, shown, AUTO_SEQ[k]); else passed++;
            if (k == 3) begin
                goto_cyc(t0 + 40);
                auto_en = 1'b0;
            end
        end
        cycles(40);
        checks++; if (n_steps - n0 !== 5) $display("FAIL auto_step_count: got %0d, expected 5", n_steps - n0); else passed++;
        checks++; if (seg_hi !== SEG_TBL[AUTO_SEQ[4][7:4]]) $display("FAIL auto_seg_hi: got %h, expected %h", seg_hi, SEG_TBL[AUTO_SEQ[4][7:4]]); else passed++;
    endtask

    // Press lands on the second auto tick (off=0), or while the sequencer
    // is in STEP (off=1) or CAP (off=2). Only the two tick-driven steps
    // may appear in every case.
    task automatic test_press_collision();
        int t0;
        int ts;
        int n0;
        for (int off = 0; off < 3; off++) begin
            do_reset();
            cycles(2);
            n0 = n_steps;
            t0 = cyc;
            auto_en = 1'b1;
            wait_step(PER + 20, ts);
            checks++; if (ts !== t0 + PER + 2) $display("FAIL coll%0d_first_step: got cycle %0d, expected %0d", off, ts, t0 + PER + 2); else passed++;
            goto_cyc(t0 + 2 * PER - DEB - 1 + off);
            key_n = 1'b0;
            wait_step(PER + 20, ts);
            checks++; if (ts !== t0 + 2 * PER + 2) $display("FAIL coll%0d_second_step: got cycle %0d, expected %0d", off, ts, t0 + 2 * PER + 2); else passed++;
            goto_cyc(t0 + 2 * PER + 4);
            auto_en = 1'b0;
            cycles(2 * DEB);
            key_n = 1'b1;
            cycles(DEB + 30);
            checks++; if (n_steps - n0 !== 2) $display("FAIL coll%0d_step_count: got %0d, expected 2", off, n_steps - n0); else passed++;
        end
    endtask

    task automatic test_reset_mid_step();
        int ts;
        int n1;
        int highs;
        do_reset();
        cycles(2);
        key_n = 1'b0;
        cycles(DEB + 8);
        key_n = 1'b1;
        cycles(DEB + 8);
        checks++; if (valid !== 1'b1) $display("FAIL rst_pre_valid: got %b, expected 1", valid); else passed++;
        key_n = 1'b0;
        wait_step(DEB + 20, ts);
        rst_n = 1'b0;
        #1;
        checks++; if (step !== 1'b0) $display("FAIL rst_step_drop: got %b, expected 0", step); else passed++;
        checks++; if (valid !== 1'b0) $display("FAIL rst_valid: got %b, expected 0", valid); else passed++;
        checks++; if (seg_hi !== 7'h7F || seg_lo !== 7'h7F) $display("FAIL rst_blank: got %h/%h, expected 7f/7f", seg_hi, seg_lo); else passed++;
        key_n = 1'b1;
        n1 = n_steps;
        cycles(3);
        rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (step !== 1'b0) highs++;
        end
        checks++; if (highs !== 0 || n_steps !== n1) $display("FAIL rst_no_spurious_step: got %0d step cycles, expected 0", highs); else passed++;
        checks++; if (valid !== 1'b0) $display("FAIL rst_post_valid: got %b, expected 0", valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_random_presses();
        test_auto();
        test_press_collision();
        test_reset_mid_step();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
